// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: fetch FSM states and the opcode
// constants that the fetch unit and the main decoder agree on.
package riscv_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_NOP    = 7'b0000000;

  localparam int INSTR_BYTES = 4;

endpackage

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: one outstanding imem request, a single holding register
// towards decode, and redirect handling that squashes in-flight responses.
module instr_fetch_unit
  import riscv_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] instr_pc,
  output logic [6:0]      op,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output fetch_state_e    dbg_state
);

  // Handshakes: a transfer happens on a cycle where valid and ready are both
  // high; valid never depends on ready, and redirect forces both of our valids low.

  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(INSTR_BYTES);
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INSTR_BYTES - 1);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic [XLEN-1:0] instr_pc_q, instr_pc_d;
  logic            kill_q, kill_d;
  logic [XLEN-1:0] target;

  assign target = redirect_pc & ~ALIGN_MASK;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      instr_pc_q <= '0;
      kill_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      kill_q     <= kill_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    instr_d        = instr_q;
    instr_pc_d     = instr_pc_q;
    kill_d         = kill_q;
    imem_req_valid = 1'b0;
    instr_valid    = 1'b0;

    unique case (state_q)
      S_REQ: begin
        imem_req_valid = !redirect_valid && !reset;
        if (redirect_valid) begin
          pc_d = target;
        end else if (imem_req_valid && imem_req_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // A response that belongs to a superseded PC is dropped, and the
        // next request goes out only after it has drained.
        if (imem_rsp_valid && redirect_valid) begin
          pc_d    = target;
          kill_d  = 1'b0;
          state_d = S_REQ;
        end else if (imem_rsp_valid && kill_q) begin
          kill_d  = 1'b0;
          state_d = S_REQ;
        end else if (imem_rsp_valid) begin
          instr_d    = imem_rsp_data;
          instr_pc_d = pc_q;
          state_d    = S_HOLD;
        end else if (redirect_valid) begin
          pc_d   = target;
          kill_d = 1'b1;
        end
      end
      S_HOLD: begin
        instr_valid = !redirect_valid && !reset;
        if (redirect_valid) begin
          pc_d    = target;
          state_d = S_REQ;
        end else if (instr_valid && instr_ready) begin
          pc_d    = pc_q + PC_STEP;
          state_d = S_REQ;
        end
      end
      default: begin
        state_d = S_REQ;
      end
    endcase
  end

  assign imem_addr = pc_q;
  assign instr     = instr_q;
  assign instr_pc  = instr_pc_q;
  assign op        = instr_valid ? instr_q[6:0] : OP_NOP;
  assign dbg_state = state_q;

endmodule
